// File: rtl/raster_pkg.sv
// raster_pkg: shared state and error-code definitions for the raster receiver.
package raster_pkg;
  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;
  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_SHORT = 2'd1;
  localparam logic [1:0] ERR_LONG  = 2'd2;
  localparam logic [1:0] ERR_SOF   = 2'd3;
endpackage

// File: rtl/raster_rx_if.sv
// raster_rx_if: pixel input stream and coordinate-tagged output stream.
interface raster_rx_if #(
  parameter int NUM_X_BITS = 10,
  parameter int NUM_Y_BITS = 10,
  parameter int DATA_BITS  = 24
);
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_sof;
  logic                  in_eol;
  logic [DATA_BITS-1:0]  in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [NUM_X_BITS-1:0] out_x;
  logic [NUM_Y_BITS-1:0] out_y;
  logic [DATA_BITS-1:0]  out_data;
  modport slave (
    input  in_valid, in_sof, in_eol, in_data, out_ready,
    output in_ready, out_valid, out_x, out_y, out_data
  );
  modport master (
    output in_valid, in_sof, in_eol, in_data, out_ready,
    input  in_ready, out_valid, out_x, out_y, out_data
  );
endinterface

// File: rtl/pos_counter.sv
// pos_counter: position counter; clr and en together load one, with limit compare flags.
module pos_counter #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] limit,
  output logic [W-1:0] q,
  output logic         at_limit,
  output logic         limit_zero
);
  logic [W-1:0] q_q, q_d;
  always_comb begin
    q_d = (clr ? '0 : q_q) + {{(W-1){1'b0}}, en};
    at_limit = q_q == limit;
    limit_zero = limit == '0;
  end
  always_ff @(posedge clk) begin
    if (rst) q_q <= '0;
    else q_q <= q_d;
  end
  assign q = q_q;
endmodule

// File: rtl/raster_rx.sv
// raster_rx: rebuilds (x, y) for a framed pixel stream, checks geometry, flags framing errors.
module raster_rx
  import raster_pkg::*;
#(
  parameter int NUM_X_BITS = 10,
  parameter int NUM_Y_BITS = 10,
  parameter int DATA_BITS  = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic [NUM_X_BITS-1:0] last_x,
  input  logic [NUM_Y_BITS-1:0] last_y,
  raster_rx_if.slave            bus,
  output logic                  frame_done,
  output logic                  err_flag,
  output logic [1:0]            err_code
);
  state_t state_q, state_d;
  logic acc, fwd, sof, x_eq, y_eq, line_end, frame_end;
  logic short_err, long_err, sof_err, err_new;
  logic [1:0] code;
  logic x_en, x_clr, y_en, y_clr, x_at, x_lz, y_at, y_lz;
  logic [NUM_X_BITS-1:0] x_q, out_x_q, out_x_d;
  logic [NUM_Y_BITS-1:0] y_q, out_y_q, out_y_d;
  logic [DATA_BITS-1:0] out_data_q, out_data_d;
  logic out_valid_q, out_valid_d, frame_done_q, frame_done_d;
  logic err_flag_q, err_flag_d;
  logic [1:0] err_code_q, err_code_d;
  pos_counter #(.W(NUM_X_BITS)) u_x (
    .clk(clk), .rst(rst), .en(x_en), .clr(x_clr), .limit(last_x),
    .q(x_q), .at_limit(x_at), .limit_zero(x_lz)
  );
  pos_counter #(.W(NUM_Y_BITS)) u_y (
    .clk(clk), .rst(rst), .en(y_en), .clr(y_clr), .limit(last_y),
    .q(y_q), .at_limit(y_at), .limit_zero(y_lz)
  );
  assign bus.in_ready = !rst && (!out_valid_q || bus.out_ready);
  // An sof beat is evaluated as if the counters already sat at (0,0).
  always_comb begin
    acc = bus.in_valid && bus.in_ready;
    sof = bus.in_sof;
    fwd = acc && (sof || state_q == ACTIVE);
    x_eq = sof ? x_lz : x_at;
    y_eq = sof ? y_lz : y_at;
    line_end = bus.in_eol && x_eq;
    frame_end = fwd && line_end && y_eq;
    short_err = bus.in_eol && !x_eq;
    long_err = !bus.in_eol && x_eq;
    sof_err = sof && state_q == ACTIVE;
    code = sof_err ? ERR_SOF : short_err ? ERR_SHORT : long_err ? ERR_LONG : ERR_NONE;
    err_new = fwd && code != ERR_NONE;
    state_d = !fwd ? state_q : (short_err || long_err) ? DRAIN : frame_end ? IDLE : ACTIVE;
    x_clr = fwd && (sof || bus.in_eol);
    x_en = fwd && !bus.in_eol;
    y_clr = fwd && (sof || frame_end);
    y_en = fwd && line_end && !y_eq;
    out_valid_d = bus.in_ready ? fwd : out_valid_q;
    out_x_d = fwd ? (sof ? '0 : x_q) : out_x_q;
    out_y_d = fwd ? (sof ? '0 : y_q) : out_y_q;
    out_data_d = fwd ? bus.in_data : out_data_q;
    frame_done_d = frame_end;
    err_flag_d = err_new || (err_flag_q && !clear);
    err_code_d = (err_new && (!err_flag_q || clear)) ? code : clear ? ERR_NONE : err_code_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      out_valid_q <= 1'b0;
      out_x_q <= '0;
      out_y_q <= '0;
      out_data_q <= '0;
      frame_done_q <= 1'b0;
      err_flag_q <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q <= state_d;
      out_valid_q <= out_valid_d;
      out_x_q <= out_x_d;
      out_y_q <= out_y_d;
      out_data_q <= out_data_d;
      frame_done_q <= frame_done_d;
      err_flag_q <= err_flag_d;
      err_code_q <= err_code_d;
    end
  end
  assign bus.out_valid = out_valid_q;
  assign bus.out_x = out_x_q;
  assign bus.out_y = out_y_q;
  assign bus.out_data = out_data_q;
  assign frame_done = frame_done_q;
  assign err_flag = err_flag_q;
  assign err_code = err_code_q;
endmodule

// File: tb/tb_raster_rx.sv
// tb_raster_rx: directed test-plan steps plus randomized traffic against a behavioural raster model.
module tb_raster_rx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear = 1'b0;
  logic [9:0] last_x = 10'd3;
  logic [9:0] last_y = 10'd1;
  logic frame_done, err_flag;
  logic [1:0] err_code;
  int checks = 0;
  int failures = 0;
  int m_mode = 0;
  int m_x = 0;
  int m_y = 0;
  int m_ec = 0;
  int m_ox = 0;
  int m_oy = 0;
  bit m_ov = 0;
  bit m_fd = 0;
  bit m_ef = 0;
  logic [23:0] m_od = '0;
  bit stall = 0;
  bit [3:0] rpat = 4'b1001;
  int pi = 0;
  bit a;
  bit s, e;

  raster_rx_if #(.NUM_X_BITS(10), .NUM_Y_BITS(10), .DATA_BITS(24)) bus ();

  raster_rx #(.NUM_X_BITS(10), .NUM_Y_BITS(10), .DATA_BITS(24)) dut (
    .clk(clk), .rst(rst), .clear(clear), .last_x(last_x), .last_y(last_y),
    .bus(bus), .frame_done(frame_done), .err_flag(err_flag), .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Mode 0 = waiting for sof, 1 = inside a frame, 2 = discarding after a line error.
  task automatic model(input bit r, rdy, sb, eb, c, acc, input logic [23:0] d);
    int px, py, ec;
    if (r) begin
      m_mode = 0; m_x = 0; m_y = 0; m_ov = 0; m_fd = 0;
      m_ef = 0; m_ec = 0; m_ox = 0; m_oy = 0; m_od = '0;
      return;
    end
    if (rdy) m_ov = 0;
    m_fd = 0;
    ec = 0;
    if (acc && (sb || m_mode == 1)) begin
      px = sb ? 0 : m_x;
      py = sb ? 0 : m_y;
      m_ov = 1; m_ox = px; m_oy = py; m_od = d;
      if (sb && m_mode == 1) ec = 3;
      else if (eb && px != int'(last_x)) ec = 1;
      else if (!eb && px == int'(last_x)) ec = 2;
      if (eb && px == int'(last_x)) begin
        m_x = 0;
        if (py == int'(last_y)) begin
          m_fd = 1; m_y = 0; m_mode = 0;
        end else begin
          m_y = py + 1; m_mode = 1;
        end
      end else if (eb || px == int'(last_x)) begin
        m_mode = 2;
      end else begin
        m_x = px + 1; m_y = py; m_mode = 1;
      end
    end
    if (ec != 0) begin
      if (!m_ef || c) m_ec = ec;
      m_ef = 1;
    end else if (c) begin
      m_ef = 0; m_ec = 0;
    end
  endtask

  task automatic step(input bit r, v, sb, eb, ord, c, input logic [23:0] d, output bit acc);
    bit rdy;
    @(negedge clk);
    rst = r; clear = c;
    bus.in_valid = v; bus.in_sof = sb; bus.in_eol = eb; bus.in_data = d;
    bus.out_ready = ord;
    #1;
    rdy = !r && (!m_ov || ord);
    chk("in_ready", 32'(bus.in_ready), 32'(rdy));
    acc = v && rdy;
    @(posedge clk);
    #1;
    model(r, rdy, sb, eb, c, acc, d);
    chk("out_valid", 32'(bus.out_valid), 32'(m_ov));
    chk("frame_done", 32'(frame_done), 32'(m_fd));
    chk("err_flag", 32'(err_flag), 32'(m_ef));
    chk("err_code", 32'(err_code), 32'(m_ec));
    if (m_ov || r) begin
      chk("out_x", 32'(bus.out_x), 32'(m_ox));
      chk("out_y", 32'(bus.out_y), 32'(m_oy));
      chk("out_data", 32'(bus.out_data), 32'(m_od));
    end
  endtask

  task automatic send(input bit sb, eb);
    bit got;
    int n;
    got = 0;
    n = 0;
    while (!got && n < 16) begin
      step(0, 1, sb, eb, stall ? rpat[pi % 4] : 1'b1, 0, 24'($urandom), got);
      pi++;
      n++;
    end
    chk("accept", 32'(got), 32'd1);
  endtask

  task automatic idle(input int n);
    bit g;
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 1, 0, 24'd0, g);
  endtask

  task automatic do_clear();
    bit g;
    step(0, 0, 0, 0, 1, 1, 24'd0, g);
  endtask

  task automatic frame();
    for (int y = 0; y <= int'(last_y); y++)
      for (int x = 0; x <= int'(last_x); x++)
        send(x == 0 && y == 0, x == int'(last_x));
  endtask

  task automatic rest_frame();
    for (int x = 1; x <= int'(last_x); x++) send(0, x == int'(last_x));
    for (int y = 1; y <= int'(last_y); y++)
      for (int x = 0; x <= int'(last_x); x++) send(0, x == int'(last_x));
  endtask

  initial begin
    step(1, 0, 0, 0, 1, 0, 24'd0, a);
    step(1, 0, 0, 0, 1, 0, 24'd0, a);
    last_x = 10'd3;
    last_y = 10'd1;
    frame();
    idle(2);
    stall = 1;
    frame();
    stall = 0;
    idle(3);
    send(1, 0); send(0, 0); send(0, 1);
    send(0, 0); send(0, 0); send(0, 0);
    do_clear();
    frame();
    send(1, 0); send(0, 0); send(0, 0); send(0, 0);
    send(0, 0);
    send(1, 0); send(0, 0); send(1, 0);
    rest_frame();
    do_clear();
    send(1, 0); send(0, 0); send(1, 0);
    rest_frame();
    idle(1);
    send(1, 0); send(0, 0); send(0, 0); send(0, 1); send(0, 0);
    step(1, 1, 0, 0, 1, 0, 24'h123456, a);
    idle(1);
    frame();
    last_x = 10'd0;
    last_y = 10'd0;
    frame();
    frame();
    idle(1);
    for (int i = 0; i < 800; i++) begin
      if (m_mode == 0 && !m_ov && $urandom_range(0, 7) == 0) begin
        last_x = 10'($urandom_range(0, 3));
        last_y = 10'($urandom_range(0, 2));
      end
      s = (m_mode == 1) ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 2) == 0);
      e = (m_x == int'(last_x)) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 9) == 0);
      step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, s, e,
           $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, 24'($urandom), a);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/raster_rx.md
# raster_rx

Receive-side raster tracker for the pixel stream path. Accepts a pixel beat stream framed by start-of-frame and end-of-line markers, rebuilds each beat's (x, y) position, and forwards it with coordinates attached to downstream consumers. It is the counterpart of the vertical/horizontal scan counters on the generating side. It also checks that incoming frame geometry matches the programmed width and height, and flags any framing violation.

## Interface
- NUM_X_BITS, 10, width of x coordinate and line-length setting
- NUM_Y_BITS, 10, width of y coordinate and frame-height setting
- DATA_BITS, 24, pixel payload width
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- clear  in  1  synchronous clear of sticky error state; does not affect the datapath
- last_x  in  NUM_X_BITS  index of the last pixel in a line (line length = last_x+1)
- last_y  in  NUM_Y_BITS  index of the last line in a frame
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_sof  in  1  beat is pixel (0,0)
- in_eol  in  1  beat is last pixel of its line
- in_data  in  DATA_BITS  pixel payload
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accept
- out_x  out  NUM_X_BITS  column of output beat
- out_y  out  NUM_Y_BITS  row of output beat
- out_data  out  DATA_BITS  payload of output beat
- frame_done  out  1  one-cycle pulse, last pixel of a well-formed frame accepted
- err_flag  out  1  sticky, set on any framing error
- err_code  out  2  code of the first error since the last clear/rst

## Operation
- States: IDLE (wait for sof), ACTIVE (in frame), DRAIN (discard until sof).
- IDLE: beats without in_sof are accepted and dropped. A beat with in_sof is forwarded at (0,0), and the block enters ACTIVE with x=1, y=0. If in_eol is also set, normal eol rules apply.
- ACTIVE, each accepted beat is forwarded at the current (x,y).
  - in_eol && x==last_x: x←0, y←y+1. If y==last_y, pulse frame_done and go to IDLE.
  - in_eol && x<last_x: SHORT_LINE error.
  - !in_eol && x==last_x: LONG_LINE error.
  - in_sof: SOF_EARLY error. The block restarts the frame at this beat: it is forwarded at (0,0) and the state stays ACTIVE.
  - Otherwise x←x+1.
- SHORT_LINE and LONG_LINE: the offending beat is still forwarded, then the block goes to DRAIN. In DRAIN, non-sof beats are dropped; an sof beat is handled exactly as in IDLE.
- Error codes (err_code, captured only while err_flag is 0): 0 NONE, 1 SHORT_LINE, 2 LONG_LINE, 3 SOF_EARLY.
- clear and a new error in the same cycle: the new error wins (err_flag=1, new code).
- last_x and last_y are sampled at every comparison. Software changes them only while in IDLE; behaviour is undefined otherwise.
- Width rule: x and y never exceed last_x and last_y. Compare with equality only; no wrap arithmetic is required.

## Timing
- Reset values: in_ready=0 during rst, then 1. out_valid=0, out_x=0, out_y=0, out_data=0, frame_done=0, err_flag=0, err_code=0. State is IDLE.
- One registered output stage, latency 1 cycle from input acceptance to out_valid.
- in_ready = !out_valid || out_ready. Full throughput, one beat per cycle, when out_ready is held high.
- out_x, out_y, and out_data hold stable while out_valid && !out_ready.
- frame_done asserts in the cycle after the final beat is accepted, coincident with that beat's out_valid.
- rst mid-frame: the output stage is emptied, the partial frame is abandoned, and no frame_done pulse is produced.

## Structure
- raster_pkg holds the state enum (IDLE, ACTIVE, DRAIN) and the err_code localparams (ERR_NONE, ERR_SHORT, ERR_LONG, ERR_SOF).
- One sub-module: pos_counter, a parameterised enable/clear/load-zero counter instantiated for x and for y. It has equality flags against a limit input.
- The top level contains the FSM, error capture, and output register.

## Test plan
- last_x=3, last_y=1, 8 clean beats (sof on the first, eol on beats 4 and 8), out_ready=1 → outputs at (0,0)…(3,0),(0,1)…(3,1); frame_done pulses once, with the (3,1) beat; err_flag=0.
- Same frame with out_ready toggling 1,0,0,1 → no beat lost or duplicated; outputs hold stable while stalled; in_ready low only while stalled and full.
- eol on the third beat with last_x=3 → beat forwarded at (2,0); err_code=1; following non-sof beats dropped until the next sof restarts at (0,0).
- No eol on the beat at x=3 → err_code=2; block in DRAIN; a later SOF_EARLY does not overwrite err_code; clear then sets err_flag=0.
- in_sof mid-line at (2,0) → err_code=3; that beat is output at (0,0); the frame completes normally after that point with frame_done.
- rst asserted for one cycle at (1,1) → all outputs return to their reset values the next cycle; the next sof frame runs cleanly.
